stage3_writeback: RTL and testbench
===================================

# stage3_writeback

Third and final pipeline stage of the 8051 core. It accepts the stage-2 output buffer through a valid/ready handshake and holds it in a one-entry register. It then commits the ALU/MOV result to internal RAM/SFR space through an acknowledged write port and updates PSW flags (CY, AC, OV). It also exposes the in-flight result for forwarding to earlier stages.

## Interface
- `BUFFER_LENGTH`, shared define: width of the stage-2 buffer. Fields: opcode[8], result[8], operand2[8], addr_op1[8], addr_op2[8], ov, ac, cy, we (LSB).
- `WIDTH`, 8: data/address width.
- `PSW_ADDR`, 8'hD0: PSW SFR address.
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_buf`  in  BUFFER_LENGTH  stage-2 output buffer.
- `i_valid`  in  1  i_buf holds a valid instruction.
- `o_ready`  out  1  stage can accept i_buf this cycle.
- `o_wr_en`  out  1  RAM/SFR write request.
- `o_wr_addr`  out  8  write address (addr_op1).
- `o_wr_data`  out  8  write data (result).
- `i_wr_ack`  in  1  write accepted this cycle.
- `o_psw_we`  out  1  one-cycle PSW flag update strobe.
- `o_psw_flags`  out  3  {cy, ac, ov} to load.
- `o_fwd_valid`  out  1  pending write visible for forwarding.
- `o_fwd_addr`  out  8  forwarded address.
- `o_fwd_data`  out  8  forwarded data.
- `o_retired`  out  16  count of retired instructions, wraps.

## Operation
- States: IDLE (empty), ISSUE (entry just captured), WAIT (write pending ack).
- Capture: `i_valid && o_ready` on a rising edge loads i_buf into the holding register and moves to ISSUE.
- ISSUE, we=1: assert o_wr_en with addr_op1/result. If i_wr_ack is high the same cycle, retire. Otherwise go to WAIT.
- ISSUE, we=0: no write; retire in this cycle.
- WAIT: hold o_wr_en, o_wr_addr and o_wr_data stable until i_wr_ack, then retire.
- Retire: o_retired increments by 1 (wraps FFFF→0000). If `i_valid && o_ready`, go to ISSUE with the new entry, otherwise go to IDLE.
- o_ready = (state==IDLE) || retiring this cycle. This allows back-to-back commits with no bubble when the ack is immediate.
- Flag update: o_psw_we pulses only in the ISSUE cycle, and only when one of these holds:
  - the opcode is ADD_*, ADDC_* or SUBB_*; or
  - the opcode is MOV_AD with addr_op1==PSW_ADDR.
- ANL/ORL/XRL/MOV otherwise and NOP produce no pulse. o_psw_flags = {cy, ac, ov} from the held entry.
- Forwarding: o_fwd_valid = holding entry valid && we. It stays high from ISSUE through the retire cycle inclusive. o_fwd_addr/o_fwd_data = addr_op1/result.
- Operand2, addr_op2 and the unused opcode bits are carried but ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, o_ready=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_psw_we=0, o_psw_flags=0, o_fwd_valid=0, o_fwd_addr=0, o_fwd_data=0, o_retired=0.
- Reset asserted mid-WAIT: the pending write is dropped, o_wr_en falls without waiting for a clock, and no retire count is taken.
- Latency: capture edge → o_wr_en and o_psw_we high in the next cycle (1 cycle). Minimum occupancy is 1 cycle per instruction.
- i_wr_ack is sampled only while o_wr_en=1; it is ignored in IDLE and for we=0 entries.
- o_psw_we is never high for more than one cycle per instruction, even when the write stalls.
- Simultaneous retire and capture: the old entry's write completes, the new entry is loaded on the same edge, and o_wr_en stays high continuously if the new entry has we=1.
- i_buf changes while o_ready=0 have no effect.

## Test plan
- Reset with i_valid high and i_wr_ack high → all outputs at reset values; no capture until i_rst_n rises.
- ADD_R, result=8'h3C, addr_op1=8'hE0, {cy,ac,ov}=3'b101, we=1, ack tied high → next cycle o_wr_en=1, addr E0, data 3C, o_psw_we=1, flags 101; o_retired=1.
- ANL_D, we=1, ack delayed 3 cycles → o_wr_en held 4 cycles with stable addr/data; o_psw_we=0; o_ready=0 until the ack cycle; o_fwd_valid high throughout.
- MOV_AD, addr_op1=8'hD0, flags 3'b011 → write to D0 plus a single o_psw_we pulse with flags 011.
- Five back-to-back valid instructions with ack always high → one retire per cycle, o_ready constant 1, o_retired=5.
- Force o_retired=16'hFFFF, retire one → 0000; assert i_rst_n=0 mid-WAIT → o_wr_en drops before the next edge.

Source files
------------

// File: rtl/stage3_writeback.sv
// stage3_writeback: final 8051 pipeline stage. Holds one stage-2 entry,
// commits its result through an acknowledged RAM/SFR write port, pulses
// the PSW flag update for arithmetic ops, and exposes the pending write
// for forwarding to earlier stages.

`ifndef BUFFER_LENGTH
`define BUFFER_LENGTH 44
`endif

module stage3_writeback #(
  parameter int          WIDTH    = 8,
  parameter logic [7:0]  PSW_ADDR = 8'hD0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [`BUFFER_LENGTH-1:0] i_buf,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_wr_en,
  output logic [WIDTH-1:0]          o_wr_addr,
  output logic [WIDTH-1:0]          o_wr_data,
  input  logic                      i_wr_ack,
  output logic                      o_psw_we,
  output logic [2:0]                o_psw_flags,
  output logic                      o_fwd_valid,
  output logic [WIDTH-1:0]          o_fwd_addr,
  output logic [WIDTH-1:0]          o_fwd_data,
  output logic [15:0]               o_retired
);

  // Buffer layout, MSB first: opcode, result, operand2, addr_op1, addr_op2, ov, ac, cy, we
  localparam int WE_BIT    = 0;
  localparam int CY_BIT    = 1;
  localparam int AC_BIT    = 2;
  localparam int OV_BIT    = 3;
  localparam int AOP2_LSB  = 4;
  localparam int AOP1_LSB  = AOP2_LSB + WIDTH;
  localparam int OPND2_LSB = AOP1_LSB + WIDTH;
  localparam int RES_LSB   = OPND2_LSB + WIDTH;
  localparam int OP_LSB    = RES_LSB + WIDTH;

  localparam logic [7:0] OP_MOV_AD = 8'hF5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [7:0]        op_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  addr_q;
  logic [2:0]        flags_q;
  logic              we_q;
  logic [15:0]       retired_q;
  logic              retiring;
  logic              ready;
  logic              capture;
  logic              arith_op;
  logic              psw_hit;
  logic              unused_fields;

  // operand2 and addr_op2 ride along in the buffer but this stage never needs them
  assign unused_fields = ^{i_buf[OPND2_LSB +: WIDTH], i_buf[AOP2_LSB +: WIDTH]};

  // ADD/ADDC/SUBB families sit in rows 2, 3 and 9 at columns 4..F
  assign arith_op = ((op_q[7:4] == 4'h2) || (op_q[7:4] == 4'h3) || (op_q[7:4] == 4'h9))
                    && (op_q[3:0] >= 4'h4);
  assign psw_hit  = arith_op || ((op_q == OP_MOV_AD) && (addr_q[7:0] == PSW_ADDR));

  // Decide whether the held entry retires this cycle and where the FSM goes next
  always_comb begin
    state_next = state;
    retiring   = 1'b0;
    ready      = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_ISSUE: retiring = !we_q || i_wr_ack;
      ST_WAIT:  retiring = i_wr_ack;
      default:  retiring = 1'b0;
    endcase
    ready   = (state == ST_IDLE) || retiring;
    capture = i_valid && ready;
    case (state)
      ST_IDLE: begin
        if (capture) state_next = ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (retiring) state_next = capture ? ST_ISSUE : ST_IDLE;
        else          state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; an async reset drops any pending write immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Holding register loads a new entry on every accepted handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= '0;
      result_q <= '0;
      addr_q   <= '0;
      flags_q  <= '0;
      we_q     <= 1'b0;
    end else if (capture) begin
      op_q     <= i_buf[OP_LSB +: 8];
      result_q <= i_buf[RES_LSB +: WIDTH];
      addr_q   <= i_buf[AOP1_LSB +: WIDTH];
      flags_q  <= {i_buf[CY_BIT], i_buf[AC_BIT], i_buf[OV_BIT]};
      we_q     <= i_buf[WE_BIT];
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      retired_q <= '0;
    else if (retiring) retired_q <= retired_q + 16'd1;
  end

  assign o_ready     = ready;
  assign o_wr_en     = ((state == ST_ISSUE) && we_q) || (state == ST_WAIT);
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = result_q;
  assign o_psw_we    = (state == ST_ISSUE) && psw_hit;
  assign o_psw_flags = flags_q;
  assign o_fwd_valid = (state != ST_IDLE) && we_q;
  assign o_fwd_addr  = addr_q;
  assign o_fwd_data  = result_q;
  assign o_retired   = retired_q;

endmodule

// File: tb/tb_stage3_writeback.sv
// tb_stage3_writeback: directed bench with a write/PSW scoreboard for stage3_writeback.

`ifndef BUFFER_LENGTH
`define BUFFER_LENGTH 44
`endif

module tb_stage3_writeback;

  logic                      clk;
  logic                      rst_n;
  logic [`BUFFER_LENGTH-1:0] i_buf;
  logic                      i_valid;
  logic                      o_ready;
  logic                      o_wr_en;
  logic [7:0]                o_wr_addr;
  logic [7:0]                o_wr_data;
  logic                      i_wr_ack;
  logic                      o_psw_we;
  logic [2:0]                o_psw_flags;
  logic                      o_fwd_valid;
  logic [7:0]                o_fwd_addr;
  logic [7:0]                o_fwd_data;
  logic [15:0]               o_retired;

  int total;
  int bad;
  logic [15:0] wr_q[$];
  logic [2:0]  psw_q[$];
  logic        psw_prev;

  stage3_writeback dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_buf       (i_buf),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_wr_ack    (i_wr_ack),
    .o_psw_we    (o_psw_we),
    .o_psw_flags (o_psw_flags),
    .o_fwd_valid (o_fwd_valid),
    .o_fwd_addr  (o_fwd_addr),
    .o_fwd_data  (o_fwd_data),
    .o_retired   (o_retired)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [`BUFFER_LENGTH-1:0] make_buf(input logic [7:0] op, input logic [7:0] res,
                                                         input logic [7:0] addr, input logic cy,
                                                         input logic ac, input logic ov, input logic we);
    return {op, res, 8'hA5, addr, 8'h5A, ov, ac, cy, we};
  endfunction

  function automatic logic expect_psw(input logic [7:0] op, input logic [7:0] addr);
    return (op >= 8'h24 && op <= 8'h2F) || (op >= 8'h34 && op <= 8'h3F) ||
           (op >= 8'h94 && op <= 8'h9F) || (op == 8'hF5 && addr == 8'hD0);
  endfunction

  // Present one entry, wait (bounded) for acceptance and record what it should produce
  task automatic apply_stimulus(input logic [`BUFFER_LENGTH-1:0] b, input bit track, output int waited);
    logic [7:0] op, res, addr;
    op   = b[43:36];
    res  = b[35:28];
    addr = b[19:12];
    i_buf   = b;
    i_valid = 1'b1;
    waited  = 0;
    @(negedge clk);
    while (!o_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 20) check_output("ready_timeout", waited, 0);
    @(posedge clk);
    if (track) begin
      if (b[0]) wr_q.push_back({addr, res});
      if (expect_psw(op, addr)) psw_q.push_back({b[1], b[2], b[3]});
    end
    #1;
    i_valid = 1'b0;
  endtask

  // Scoreboard: compare each completed write and each PSW pulse with what was queued
  always @(negedge clk) begin
    logic [15:0] w;
    logic [2:0]  f;
    if (rst_n) begin
      if (o_wr_en && i_wr_ack) begin
        check_output("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check_output("sb_wr_addr", o_wr_addr, w[15:8]);
          check_output("sb_wr_data", o_wr_data, w[7:0]);
        end
      end
      if (o_psw_we) begin
        check_output("psw_single_cycle", psw_prev, 0);
        check_output("psw_expected", psw_q.size() != 0, 1);
        if (psw_q.size() != 0) begin
          f = psw_q.pop_front();
          check_output("sb_psw_flags", o_psw_flags, f);
        end
      end
      psw_prev = o_psw_we;
    end else begin
      psw_prev = 1'b0;
    end
  end

  // Directed sequence
  initial begin
    int waited;
    logic [15:0] exp_ret;
    logic [`BUFFER_LENGTH-1:0] bufs [5];
    total    = 0;
    bad      = 0;
    psw_prev = 1'b0;
    exp_ret  = 16'd0;

    // Reset with valid and ack both high: nothing may be captured
    rst_n    = 1'b0;
    i_valid  = 1'b1;
    i_wr_ack = 1'b1;
    i_buf    = make_buf(8'h28, 8'h77, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    check_output("rst_ready", o_ready, 1);
    check_output("rst_wr_en", o_wr_en, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_wr_en_clk", o_wr_en, 0);
    check_output("rst_wr_addr", o_wr_addr, 0);
    check_output("rst_wr_data", o_wr_data, 0);
    check_output("rst_psw_we", o_psw_we, 0);
    check_output("rst_psw_flags", o_psw_flags, 0);
    check_output("rst_fwd_valid", o_fwd_valid, 0);
    check_output("rst_fwd_addr", o_fwd_addr, 0);
    check_output("rst_fwd_data", o_fwd_data, 0);
    check_output("rst_retired", o_retired, 0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    check_output("post_rst_no_capture", o_wr_en, 0);

    // ADD_R with immediate ack: write and PSW pulse one cycle after capture
    @(posedge clk); #1;
    apply_stimulus(make_buf(8'h28, 8'h3C, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, waited);
    exp_ret++;
    @(negedge clk);
    check_output("add_wr_en", o_wr_en, 1);
    check_output("add_wr_addr", o_wr_addr, 8'hE0);
    check_output("add_wr_data", o_wr_data, 8'h3C);
    check_output("add_psw_we", o_psw_we, 1);
    check_output("add_psw_flags", o_psw_flags, 3'b101);
    check_output("add_fwd_valid", o_fwd_valid, 1);
    check_output("add_fwd_addr", o_fwd_addr, 8'hE0);
    check_output("add_fwd_data", o_fwd_data, 8'h3C);
    @(posedge clk); #1;
    check_output("add_retired", o_retired, exp_ret);
    check_output("add_wr_en_after", o_wr_en, 0);

    // ANL_D with ack delayed three cycles: write held four cycles
    i_wr_ack = 1'b0;
    apply_stimulus(make_buf(8'h55, 8'h81, 8'h42, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1, waited);
    exp_ret++;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) i_wr_ack = 1'b1;
      @(negedge clk);
      check_output("anl_wr_en", o_wr_en, 1);
      check_output("anl_wr_addr", o_wr_addr, 8'h42);
      check_output("anl_wr_data", o_wr_data, 8'h81);
      check_output("anl_psw_we", o_psw_we, 0);
      check_output("anl_ready", o_ready, (k == 3) ? 1 : 0);
      check_output("anl_fwd_valid", o_fwd_valid, 1);
      @(posedge clk); #1;
    end
    check_output("anl_wr_en_after", o_wr_en, 0);
    check_output("anl_retired", o_retired, exp_ret);

    // MOV_AD to PSW with a one-cycle stall: exactly one flag pulse
    i_wr_ack = 1'b0;
    apply_stimulus(make_buf(8'hF5, 8'h19, 8'hD0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1, waited);
    exp_ret++;
    @(negedge clk);
    check_output("mov_psw_we", o_psw_we, 1);
    check_output("mov_psw_flags", o_psw_flags, 3'b011);
    check_output("mov_wr_addr", o_wr_addr, 8'hD0);
    @(posedge clk); #1;
    i_wr_ack = 1'b1;
    @(negedge clk);
    check_output("mov_psw_we_stall", o_psw_we, 0);
    check_output("mov_wr_en_stall", o_wr_en, 1);
    @(posedge clk); #1;
    check_output("mov_retired", o_retired, exp_ret);

    // Five back-to-back entries with ack high: no bubbles
    bufs[0] = make_buf(8'h25, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1);
    bufs[1] = make_buf(8'h00, 8'h11, 8'h21, 1'b1, 1'b1, 1'b1, 1'b0);
    bufs[2] = make_buf(8'h45, 8'h12, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    bufs[3] = make_buf(8'h95, 8'h13, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1);
    bufs[4] = make_buf(8'hF5, 8'h14, 8'h30, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(bufs[i], 1'b1, waited);
      exp_ret++;
      check_output("b2b_no_stall", waited, 0);
    end
    @(negedge clk);
    check_output("b2b_ready_last", o_ready, 1);
    @(posedge clk); #1;
    check_output("b2b_retired", o_retired, exp_ret);

    // Counter wrap from FFFF using a no-write entry
    force dut.retired_q = 16'hFFFF;
    #1;
    check_output("wrap_forced", o_retired, 16'hFFFF);
    release dut.retired_q;
    apply_stimulus(make_buf(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, waited);
    @(negedge clk);
    check_output("nop_wr_en", o_wr_en, 0);
    check_output("nop_fwd_valid", o_fwd_valid, 0);
    @(posedge clk); #1;
    check_output("wrap_retired", o_retired, 16'h0000);

    // Reset while a write is waiting for ack: write dropped without a clock
    i_wr_ack = 1'b0;
    apply_stimulus(make_buf(8'h55, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, waited);
    @(negedge clk);
    check_output("midwait_wr_en_issue", o_wr_en, 1);
    @(posedge clk); #1;
    check_output("midwait_wr_en_wait", o_wr_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midwait_wr_en_drop", o_wr_en, 0);
    check_output("midwait_fwd_valid", o_fwd_valid, 0);
    check_output("midwait_ready", o_ready, 1);
    check_output("midwait_wr_addr", o_wr_addr, 0);
    i_wr_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("midwait_retired", o_retired, 0);
    check_output("midwait_wr_en_after", o_wr_en, 0);

    // All queued writes and flag pulses must have been observed
    check_output("wr_q_drained", wr_q.size(), 0);
    check_output("psw_q_drained", psw_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
